// File: rtl/bird_flap_draw.sv
// Bird sprite pixel stage: wing-flap phase timing plus registered bitmap lookup.
// Optional hit blink is built only when BIRD_HIT_BLINK_EN is defined.
module bird_flap_draw #(
   parameter int unsigned FRAMES_PER_FLAP       = 6,
   parameter logic [7:0]  TRANSPARENT_ENCODING  = 8'hFF,
   parameter int unsigned OBJECT_NUMBER_OF_BITS = 5
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        InsideRectangle,
   input  logic [10:0] offsetX,
   input  logic [10:0] offsetY,
   input  logic        flying,
   input  logic [0:(2**OBJECT_NUMBER_OF_BITS)-1][0:(2**OBJECT_NUMBER_OF_BITS)-1][7:0] wings_up_object_colors,
   input  logic [0:(2**OBJECT_NUMBER_OF_BITS)-1][0:(2**OBJECT_NUMBER_OF_BITS)-1][7:0] wings_down_object_colors,
   input  logic        hitPulse,
   output logic        drawingRequest,
   output logic [7:0]  RGBout,
   output logic        wingPhase
);

   localparam int unsigned NB        = OBJECT_NUMBER_OF_BITS;
   localparam logic [5:0]  LAST_FRAME = 6'(FRAMES_PER_FLAP - 1);

   logic [5:0]    frame_cnt;
   logic          frame_tick;
   logic          in_box;
   logic [NB-1:0] pix_x;
   logic [NB-1:0] pix_y;
   logic [7:0]    colour;
   logic          blink_off;

   assign frame_tick = startOfFrame & flying;

   // Phase only moves on a frame edge so a whole frame is drawn from one bitmap.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         frame_cnt <= '0;
         wingPhase <= 1'b0;
      end else if (frame_tick) begin
         if (frame_cnt == LAST_FRAME) begin
            frame_cnt <= '0;
            wingPhase <= ~wingPhase;
         end else begin
            frame_cnt <= frame_cnt + 6'd1;
         end
      end
   end

   assign pix_x  = offsetX[NB-1:0];
   assign pix_y  = offsetY[NB-1:0];
   assign in_box = InsideRectangle
                   && (offsetX[10:NB] == '0)
                   && (offsetY[10:NB] == '0);

   always_comb begin
      colour = wings_up_object_colors[pix_y][pix_x];
      if (wingPhase) begin
         colour = wings_down_object_colors[pix_y][pix_x];
      end
   end

`ifdef BIRD_HIT_BLINK_EN
   logic [4:0] blink_cnt;

   // Down-counter in frames; a new hit restarts the full blink.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         blink_cnt <= '0;
      end else if (hitPulse) begin
         blink_cnt <= 5'd24;
      end else if (startOfFrame && (blink_cnt != '0)) begin
         blink_cnt <= blink_cnt - 5'd1;
      end
   end

   assign blink_off = (blink_cnt != '0) && blink_cnt[2];
`else
   logic unused_hit;
   assign unused_hit = hitPulse;
   assign blink_off  = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         drawingRequest <= 1'b0;
         RGBout         <= 8'h00;
      end else begin
         drawingRequest <= in_box && (colour != TRANSPARENT_ENCODING) && !blink_off;
         RGBout         <= in_box ? colour : 8'h00;
      end
   end

endmodule

// File: tb/tb_bird_flap_draw.sv
// Directed bench for bird_flap_draw with a frame-count based reference model.
// Blink scenarios run only when BIRD_HIT_BLINK_EN is defined.
module tb_bird_flap_draw;

   localparam int FPF = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetN = 1'b0;
   logic        startOfFrame = 1'b0;
   logic        InsideRectangle = 1'b0;
   logic        flying = 1'b0;
   logic        hitPulse = 1'b0;
   logic [10:0] offsetX = '0;
   logic [10:0] offsetY = '0;
   logic [0:31][0:31][7:0] up_bm;
   logic [0:31][0:31][7:0] dn_bm;
   logic        drawingRequest;
   logic [7:0]  RGBout;
   logic        wingPhase;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: frames counted since reset, frames seen since last hit.
   int counted = 0;
   int sof_since_hit = 0;
   bit blink_active = 1'b0;

   logic       exp_req = 1'b0;
   logic [7:0] exp_rgb = 8'h00;
   logic       exp_phase = 1'b0;

   bird_flap_draw dut (
      .clk                      (clk),
      .resetN                   (resetN),
      .startOfFrame             (startOfFrame),
      .InsideRectangle          (InsideRectangle),
      .offsetX                  (offsetX),
      .offsetY                  (offsetY),
      .flying                   (flying),
      .wings_up_object_colors   (up_bm),
      .wings_down_object_colors (dn_bm),
      .hitPulse                 (hitPulse),
      .drawingRequest           (drawingRequest),
      .RGBout                   (RGBout),
      .wingPhase                (wingPhase)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic bit model_phase();
      return ((counted / FPF) % 2) == 1;
   endfunction

   always @(negedge clk) begin
      check("cyc_req", drawingRequest, exp_req);
      check("cyc_rgb", RGBout, exp_rgb);
      check("cyc_phase", wingPhase, exp_phase);
   end

   task automatic step();
      bit         ph;
      bit         in_box;
      bit         kill;
      int         rem;
      logic [7:0] col;
      ph     = model_phase();
      in_box = InsideRectangle && (offsetX < 32) && (offsetY < 32);
      col    = ph ? dn_bm[offsetY[4:0]][offsetX[4:0]] : up_bm[offsetY[4:0]][offsetX[4:0]];
      rem    = blink_active ? (24 - sof_since_hit) : 0;
      kill   = (rem > 0) && ((rem % 8) >= 4);
      if (startOfFrame && flying) counted++;
`ifdef BIRD_HIT_BLINK_EN
      if (hitPulse) begin
         blink_active  = 1'b1;
         sof_since_hit = 0;
      end else if (startOfFrame && blink_active && sof_since_hit < 24) begin
         sof_since_hit++;
      end
`endif
      @(posedge clk);
      #1;
      exp_req   = in_box && (col != 8'hFF) && !kill;
      exp_rgb   = in_box ? col : 8'h00;
      exp_phase = model_phase();
   endtask

   task automatic frame_pulse();
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
      step();
   endtask

   task automatic do_reset();
      #2;
      resetN          = 1'b0;
      startOfFrame    = 1'b0;
      hitPulse        = 1'b0;
      counted         = 0;
      sof_since_hit   = 0;
      blink_active    = 1'b0;
      exp_req         = 1'b0;
      exp_rgb         = 8'h00;
      exp_phase       = 1'b0;
      #1;
      check("rst_req", drawingRequest, 1'b0);
      check("rst_rgb", RGBout, 8'h00);
      check("rst_phase", wingPhase, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      resetN = 1'b1;
   endtask

   initial begin
      for (int y = 0; y < 32; y++) begin
         for (int x = 0; x < 32; x++) begin
            up_bm[y][x] = 8'((y * 13 + x * 5) % 250);
            dn_bm[y][x] = 8'((y * 7 + x * 11 + 100) % 250);
         end
      end
      up_bm[1][1]  = 8'h33;
      up_bm[0][5]  = 8'hFF;
      dn_bm[3][3]  = 8'hFF;
      up_bm[5][15] = 8'hF9;
      dn_bm[5][15] = 8'hF9;
      up_bm[0][0]  = 8'h10;
      dn_bm[0][0]  = 8'h20;

      #1;
      check("init_req", drawingRequest, 1'b0);
      check("init_rgb", RGBout, 8'h00);
      check("init_phase", wingPhase, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      resetN = 1'b1;

      // Phase timing over 12 frames
      flying = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         frame_pulse();
         check("t1_phase", wingPhase, (i >= 6 && i < 12) ? 1 : 0);
      end

      // Opaque and transparent pixels in phase 0
      InsideRectangle = 1'b1;
      offsetX = 11'd1; offsetY = 11'd1;
      step();
      check("t2_req_33", drawingRequest, 1'b1);
      check("t2_rgb_33", RGBout, 8'h33);
      offsetX = 11'd5; offsetY = 11'd0;
      step();
      check("t2_req_ff", drawingRequest, 1'b0);
      check("t2_rgb_ff", RGBout, 8'hFF);

      // Outside the box
      offsetX = 11'd32;
      step();
      check("t3_x32_req", drawingRequest, 1'b0);
      check("t3_x32_rgb", RGBout, 8'h00);
      offsetX = 11'd40;
      step();
      check("t3_x40_req", drawingRequest, 1'b0);
      offsetX = 11'd3; offsetY = 11'd33;
      step();
      check("t3_y33_rgb", RGBout, 8'h00);
      InsideRectangle = 1'b0;
      offsetX = 11'd2; offsetY = 11'd2;
      step();
      check("t3_outside_req", drawingRequest, 1'b0);
      check("t3_outside_rgb", RGBout, 8'h00);

      for (int i = 0; i < 40; i++) begin
         InsideRectangle = ($urandom_range(0, 3) != 0);
         offsetX = 11'($urandom_range(0, 35));
         offsetY = 11'($urandom_range(0, 35));
         step();
      end
      InsideRectangle = 1'b0;

      // Freeze at counter 3, then resume with flying and startOfFrame together
      repeat (3) frame_pulse();
      flying = 1'b0;
      repeat (20) frame_pulse();
      check("t4_frozen", wingPhase, 1'b0);
      startOfFrame = 1'b1;
      flying = 1'b1;
      step();
      startOfFrame = 1'b0;
      step();
      check("t4_res1", wingPhase, 1'b0);
      frame_pulse();
      check("t4_res2", wingPhase, 1'b0);
      frame_pulse();
      check("t4_res3", wingPhase, 1'b1);

      // Pixel coincident with phase toggle uses the old phase
      repeat (5) frame_pulse();
      InsideRectangle = 1'b1;
      offsetX = 11'd15; offsetY = 11'd5;
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
      check("t5_f9_rgb", RGBout, 8'hF9);
      check("t5_f9_req", drawingRequest, 1'b1);
      check("t5_toggled", wingPhase, 1'b0);
      offsetX = 11'd0; offsetY = 11'd0;
      step();
      check("t5_new_up", RGBout, 8'h10);
      repeat (5) frame_pulse();
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
      check("t5_old_up", RGBout, 8'h10);
      step();
      check("t5_new_down", RGBout, 8'h20);

      // Asynchronous reset mid-frame, then restart from phase 0
      do_reset();
      step();
      repeat (5) frame_pulse();
      check("t_rst_p5", wingPhase, 1'b0);
      frame_pulse();
      check("t_rst_p6", wingPhase, 1'b1);

`ifdef BIRD_HIT_BLINK_EN
      offsetX = 11'd1; offsetY = 11'd1;
      up_bm[1][1] = 8'h33;
      hitPulse = 1'b1;
      step();
      hitPulse = 1'b0;
      step();
      check("t6_hit_on", drawingRequest, 1'b1);
      for (int f = 1; f <= 36; f++) begin
         frame_pulse();
         if (f == 1)  check("t6_f1_off", drawingRequest, 1'b0);
         if (f == 5)  check("t6_f5_on", drawingRequest, 1'b1);
         if (f == 11) check("t6_f11_off", drawingRequest, 1'b0);
         if (f == 30) check("t6_f30_off", drawingRequest, 1'b0);
         if (f == 34) check("t6_f34_on", drawingRequest, 1'b1);
         if (f == 10) begin
            hitPulse = 1'b1;
            step();
            hitPulse = 1'b0;
         end
      end
`endif

      repeat (2) step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
